// File: rtl/conv_mac_pkg.sv
// Shared types and sizing for the convolution MAC stage.
// Windows and kernels are LEN signed samples; results are wide enough to never wrap.
package conv_mac_pkg;

    localparam int LEN   = 4;
    localparam int WIDTH = 8;
    localparam int RES_W = 2 * WIDTH + $clog2(LEN) + 1;
    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int PROD_W = 2 * WIDTH;

    typedef logic signed [WIDTH-1:0] data_t;

    // data[0] is the oldest sample of the window.
    typedef struct packed {
        data_t [LEN-1:0] data;
    } data_vector;

    typedef logic signed [RES_W-1:0] result_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    function automatic result_t sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(RES_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/conv_mac_mul.sv
// Combinational signed WIDTH x WIDTH multiplier, kept separate so a DSP-mapped
// or pipelined implementation can replace it without touching the controller.
module conv_mac_mul
    import conv_mac_pkg::*;
(
    input  logic  [WIDTH-1:0]        a_i,
    input  logic  [WIDTH-1:0]        b_i,
    output logic  [PROD_W-1:0]       p_o
);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;

    assign a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_ext = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/conv_mac.sv
// Sequential dot-product engine: captures one window and kernel, accumulates one
// product per cycle through a shared multiplier, and offers the sum on a valid/ready port.
module conv_mac
    import conv_mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  data_vector in_data,
    input  data_vector kernel,
    input  logic       in_valid,
    output logic       in_ready,
    output result_t    result,
    output logic       out_valid,
    input  logic       out_ready,
    output state_e     dbg_state_o
);

    // Handshakes: a transfer happens on a posedge where valid and ready are both
    // high; valid holds its payload until then, ready may be registered freely.

    state_e              state_q;
    data_vector          d_q;
    data_vector          k_q;
    result_t             acc_q;
    result_t             result_q;
    logic [IDX_W-1:0]    idx_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [PROD_W-1:0]   prod;
    result_t             sum_d;

    conv_mac_mul u_mul (
        .a_i (d_q.data[idx_q]),
        .b_i (k_q.data[idx_q]),
        .p_o (prod)
    );

    assign sum_d = acc_q + sext_prod(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_ready_q && in_valid) begin
                        d_q        <= in_data;
                        k_q        <= kernel;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q <= sum_d;
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        result_q    <= sum_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    acc_q       <= '0;
                    result_q    <= '0;
                    idx_q       <= '0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_conv_mac.sv
// Randomized and directed checks of conv_mac against a plain-arithmetic dot-product model.
module tb_conv_mac;
    import conv_mac_pkg::*;

    logic       clk;
    logic       rst;
    data_vector in_data;
    data_vector kernel;
    logic       in_valid;
    logic       in_ready;
    result_t    result;
    logic       out_valid;
    logic       out_ready;
    state_e     dbg_state;

    int n_vec;
    int n_err;
    int cyc;
    bit rand_bp;

    logic [RES_W-1:0] exp_q[$];
    int               hs_q[$];

    conv_mac dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .kernel      (kernel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result      (result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic result_t ref_dot(input data_vector d, input data_vector k);
        longint s;
        s = 0;
        for (int i = 0; i < LEN; i++) s += longint'(d.data[i]) * longint'(k.data[i]);
        return result_t'(s);
    endfunction

    function automatic data_vector mk(input int a0, input int a1, input int a2, input int a3);
        data_vector v;
        v.data[0] = data_t'(a0);
        v.data[1] = data_t'(a1);
        v.data[2] = data_t'(a2);
        v.data[3] = data_t'(a3);
        return v;
    endfunction

    function automatic data_vector rnd_vec();
        data_vector v;
        for (int i = 0; i < LEN; i++) v.data[i] = data_t'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input data_vector d, input data_vector k);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = d;
        kernel   = k;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(ref_dot(d, k));
        hs_q.push_back(cyc);
        in_valid = 1'b0;
        in_data  = rnd_vec();
        kernel   = rnd_vec();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Random backpressure, changed just after each posedge so it is stable at sampling.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- scoreboard monitor ----------------
    bit prev_ov;
    bit exp_ready_next;

    always @(negedge clk) begin
        if (rst) begin
            prev_ov        = 1'b0;
            exp_ready_next = 1'b0;
        end else begin
            if (exp_ready_next) begin
                check("in_ready_after_xfer", in_ready, 1);
                exp_ready_next = 1'b0;
            end
            if (out_valid && in_ready) check("ready_valid_exclusive", 1, 0);
            if (out_valid && !prev_ov && hs_q.size() != 0)
                check("out_valid_latency", cyc - hs_q[0], LEN);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", result, 0);
                    check("unexpected_output_valid", 1, 0);
                end else begin
                    check("result", result, result_t'(exp_q.pop_front()));
                    void'(hs_q.pop_front());
                end
                exp_ready_next = 1'b1;
            end
            prev_ov = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        result_t    e;
        data_vector samp;
        int         n;
        n_vec     = 0;
        n_err     = 0;
        rand_bp   = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        kernel    = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // 1 Basic
        send(mk(1, 2, 3, 4), mk(1, 1, 1, 1));
        drain();
        check("basic_model", ref_dot(mk(1, 2, 3, 4), mk(1, 1, 1, 1)), 10);

        // 2 Signed
        send(mk(-1, 2, -3, 4), mk(2, -2, 2, -2));
        send(mk(127, 127, 127, 127), mk(-128, -128, -128, -128));
        // 3 Extremes
        send(mk(-128, -128, -128, -128), mk(-128, -128, -128, -128));
        drain();
        check("model_signed", ref_dot(mk(-1, 2, -3, 4), mk(2, -2, 2, -2)), -20);
        check("model_extreme", ref_dot(mk(-128, -128, -128, -128), mk(-128, -128, -128, -128)), 65536);

        // 4 Backpressure with upstream churn
        out_ready = 1'b0;
        send(mk(5, -6, 7, -8), mk(3, 3, -3, -3));
        e = ref_dot(mk(5, -6, 7, -8), mk(3, 3, -3, -3));
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = rnd_vec();
            kernel   = rnd_vec();
            check("bp_result_stable", result, e);
            check("bp_out_valid_hold", out_valid, 1);
            check("bp_in_ready_low", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // 5 Reset mid-CALC
        send(mk(9, 9, 9, 9), mk(9, 9, 9, 9));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_state", dbg_state, IDLE);
        void'(exp_q.pop_back());
        void'(hs_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        send(mk(4, 3, 2, 1), mk(1, 1, 1, 1));
        drain();

        // 6 Streaming windows from a shifting sample sequence
        for (int s = 0; s + LEN <= 8; s++) begin
            for (int i = 0; i < LEN; i++) samp.data[i] = data_t'(s + i + 1);
            send(samp, mk(1, 1, 1, 1));
        end
        drain();

        // Random windows under random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) send(rnd_vec(), rnd_vec());
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
